score_display: RTL

- Downstream consumer of the 3-digit BCD score counter. Drives the board's 4-digit multiplexed, common-anode 7-segment display.
- Digits 0-2 show the BCD score with leading-zero blanking. Digit 3 shows remaining lives, with its decimal point lit as a separator.
- Score and lives are snapshotted once per scan frame so the display never tears. A game-over blink mode is included.

---
 rtl/score_display_pkg.sv | 30 +++
 rtl/score_display_seg_decoder.sv | 26 ++
 rtl/score_display.sv | 128 ++++++++++++
 3 files changed

// File: rtl/score_display_pkg.sv
// Shared constants for the score display: active-low segment patterns and anode selects.
// Also reusable by other multiplexed 7-segment display blocks.
package score_display_pkg;

    // Segment bit positions, active-low: seg[0]=a .. seg[6]=g, seg[7]=dp.
    localparam int unsigned DP_BIT = 7;

    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] AN_OFF = 4'hF;
    localparam logic [3:0] AN_ONEHOT [0:3] = '{4'hE, 4'hD, 4'hB, 4'h7};

    localparam logic [1:0] IDX_ONES     = 2'd0;
    localparam logic [1:0] IDX_TENS     = 2'd1;
    localparam logic [1:0] IDX_HUNDREDS = 2'd2;
    localparam logic [1:0] IDX_LIVES    = 2'd3;

    function automatic logic [7:0] seg_with_dp(input logic [7:0] pattern);
        logic [7:0] result;
        result         = pattern;
        result[DP_BIT] = 1'b0;
        return result;
    endfunction

endpackage

// File: rtl/score_display_seg_decoder.sv
// Nibble to active-low 7-segment pattern, dp off. Non-BCD nibbles show a dash.
module seg_decoder
    import score_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (nibble_i)
            4'd0:    seg_o = SEG_DIGIT[0];
            4'd1:    seg_o = SEG_DIGIT[1];
            4'd2:    seg_o = SEG_DIGIT[2];
            4'd3:    seg_o = SEG_DIGIT[3];
            4'd4:    seg_o = SEG_DIGIT[4];
            4'd5:    seg_o = SEG_DIGIT[5];
            4'd6:    seg_o = SEG_DIGIT[6];
            4'd7:    seg_o = SEG_DIGIT[7];
            4'd8:    seg_o = SEG_DIGIT[8];
            4'd9:    seg_o = SEG_DIGIT[9];
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Multiplexed 4-digit common-anode display: 3 BCD score digits with leading-zero blanking
// plus a lives digit with dp. Inputs are snapshotted per frame; optional game-over blink.
module score_display
    import score_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [11:0] score,
    input  logic [3:0]  lives,
    input  logic        game_over,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [11:0]      snap_score_q, snap_score_d;
    logic [3:0]       snap_lives_q, snap_lives_d;
    logic [FR_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic             phase_q, phase_d;
    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;

    logic       tick;
    logic       frame_end;
    logic [3:0] digit_val;
    logic [7:0] dec_seg;
    logic       blank_digit;

    assign tick      = (tick_cnt_q == CNT_LAST);
    assign frame_end = tick && (idx_q == IDX_LIVES);

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
        idx_d      = tick ? idx_q + 2'd1 : idx_q;
    end

    always_comb begin
        snap_score_d = snap_score_q;
        snap_lives_d = snap_lives_q;
        if (frame_end) begin
            snap_score_d = score;
            snap_lives_d = lives;
        end
    end

    // Blink phase only advances while game_over is held; dropping it resets to the visible phase.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (!game_over) begin
            frame_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (frame_end) begin
            if (frame_cnt_q == FR_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FR_W'(1);
            end
        end
    end

    always_comb begin
        digit_val   = snap_lives_q;
        blank_digit = 1'b0;
        case (idx_q)
            IDX_ONES: digit_val = snap_score_q[3:0];
            IDX_TENS: begin
                digit_val   = snap_score_q[7:4];
                blank_digit = (snap_score_q[11:4] == 8'h00);
            end
            IDX_HUNDREDS: begin
                digit_val   = snap_score_q[11:8];
                blank_digit = (snap_score_q[11:8] == 4'h0);
            end
            default: digit_val = snap_lives_q;
        endcase
    end

    seg_decoder u_seg_decoder (
        .nibble_i (digit_val),
        .seg_o    (dec_seg)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (!blank_digit && !(phase_q && game_over)) begin
            an_d  = AN_ONEHOT[idx_q];
            seg_d = (idx_q == IDX_LIVES) ? seg_with_dp(dec_seg) : dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tick_cnt_q   <= '0;
            idx_q        <= 2'd0;
            snap_score_q <= 12'h000;
            snap_lives_q <= 4'h0;
            frame_cnt_q  <= '0;
            phase_q      <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            idx_q        <= idx_d;
            snap_score_q <= snap_score_d;
            snap_lives_q <= snap_lives_d;
            frame_cnt_q  <= frame_cnt_d;
            phase_q      <= phase_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule
